lcd_spi_decoder: RTL and testbench
==================================

# lcd_spi_decoder

Passive receive-side decoder for the 4-wire LCD SPI bus (SCL, MOSI, CS, DC, plus panel RST) that our init/pixel master drives. It oversamples the bus on the system clock, reassembles MSB-first bytes, classifies each as command or parameter using DC, and tracks the active command and the parameter index within it. It sits beside the master in the demo top level as a wave-decode/self-check tap and must never drive the bus.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops per bus input (minimum 2).
- IDX_W, 14: width of the parameter index counter; covers a 12800-byte pixel burst.

Ports:
- CLK  in  1  system clock; sole clock.
- RST_N  in  1  reset, synchronous and active-low.
- SCL  in  1  bus clock, asynchronous to CLK; data sampled on rising edge.
- MOSI  in  1  bus data, MSB first.
- CS  in  1  chip select, active-low.
- DC  in  1  0 = command byte, 1 = parameter/pixel byte.
- LCD_RST  in  1  panel reset line, active-low.
- BYTE_VALID  out  1  one-cycle pulse per completed byte.
- BYTE_DATA  out  8  completed byte; held until next BYTE_VALID.
- BYTE_IS_CMD  out  1  DC captured at the byte's 8th SCL rising edge, inverted.
- CUR_CMD  out  8  last command byte received.
- PARAM_IDX  out  IDX_W  index of current parameter byte within CUR_CMD (0-based).
- FRAG_ERR  out  1  one-cycle pulse when CS deasserts mid-byte.
- PANEL_RST_SEEN  out  1  sticky; set on any LCD_RST low sample, cleared only by RST_N.

## Operation
- All five bus inputs pass through SYNC_STAGES flops; SCL rising edge detected from last two synchronized samples.
- FSM states: IDLE (CS high or after reset), SHIFT (CS low, collecting bits).
  - IDLE -> SHIFT: synchronized CS low. bit_cnt cleared to 0.
  - SHIFT, SCL rising: shift MOSI into shreg; bit_cnt increments. On 8th rise: BYTE_DATA <= {shreg[6:0], MOSI}, BYTE_IS_CMD <= ~DC, BYTE_VALID pulses, bit_cnt <= 0, stay SHIFT (multi-byte frames under one CS are legal).
  - SHIFT, CS high: if bit_cnt != 0, pulse FRAG_ERR and discard partial bits; -> IDLE.
- Command tracking on each completed byte:
  - Command byte: CUR_CMD <= byte; PARAM_IDX <= 0; internal first_param flag set.
  - Parameter byte: first after a command reports PARAM_IDX = 0; each subsequent increments by 1; saturates at all-ones (no wrap).
  - Parameter before any command since reset: CUR_CMD stays 0x00, PARAM_IDX counts normally.
- Synchronized LCD_RST low: FSM -> IDLE, bit_cnt/shreg cleared, CUR_CMD <= 0x00, PARAM_IDX <= 0, PANEL_RST_SEEN <= 1; no BYTE_VALID or FRAG_ERR generated that cycle.
- Simultaneous 8th SCL rise and CS deassertion in the same synchronized sample: byte completes (BYTE_VALID), no FRAG_ERR.

## Timing
- Reset (RST_N low at CLK edge): all outputs 0, FSM IDLE, counters 0.
- Bus requirement: SCL high and low phases each >= 2 CLK cycles after synchronization; otherwise edges are missed (not detected, not flagged). Master must run SCL at <= CLK/4 when this tap is enabled.
- Latency: BYTE_VALID asserts SYNC_STAGES+1 CLK cycles after the 8th SCL rising edge at the pin; CUR_CMD/PARAM_IDX update in that same cycle.
- FRAG_ERR asserts SYNC_STAGES+1 cycles after CS rises at the pin.
- No backpressure: consumer must accept BYTE_VALID every cycle it appears.

## Structure
- Shared package lcd_spi_pkg: FSM state encoding, command constants (CMD_NOP 0x00, CMD_CASET 0x2A, CMD_RASET 0x2B, CMD_RAMWR 0x2C), default IDX_W; the master should adopt the same constants.
- One sub-module: lcd_spi_sync (parameterized N-bit, SYNC_STAGES-deep synchronizer with SCL rise detect). Everything else in lcd_spi_decoder.

## Test plan
- CS low, DC=0, send 0xB1, DC=1, send 0x05 0x3C 0x3C, CS high between bytes -> four BYTE_VALID: B1/cmd, then 05,3C,3C with CUR_CMD=0xB1, PARAM_IDX=0,1,2; no FRAG_ERR.
- Send 0x2C then 12800 bytes 0xFF under one CS -> last PARAM_IDX=12799, CUR_CMD=0x2C throughout.
- CS high after 5 bits of 0xA0 -> FRAG_ERR one pulse, no BYTE_VALID; next full 0x29 decodes correctly as cmd.
- LCD_RST low mid-byte after 0x36 cmd -> CUR_CMD=0x00, PANEL_RST_SEEN=1, no BYTE_VALID/FRAG_ERR; post-release 0x3A decodes.
- Measure latency: 8th SCL rise at pin to BYTE_VALID = 3 CLK (SYNC_STAGES=2); 8th rise coincident with CS rise -> byte valid, no FRAG_ERR.
- RST_N low mid-frame -> all outputs 0 next cycle; first byte after release decodes from bit 0.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI bus: FSM encoding, command opcodes and
// the synchronized bus bit layout used by the receive-side decoder.
package lcd_spi_pkg;

    // Receive FSM: IDLE while CS is high, SHIFT while collecting bits.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } lcd_spi_state_e;

    // Command opcodes shared with the init/pixel master.
    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Parameter index width; 14 bits covers a 12800-byte pixel burst.
    localparam int IDX_W_DEF = 14;

    // Bit positions of the bus signals inside the synchronized vector.
    localparam int BUS_W    = 5;
    localparam int BUS_SCL  = 0;
    localparam int BUS_MOSI = 1;
    localparam int BUS_CS   = 2;
    localparam int BUS_DC   = 3;
    localparam int BUS_RST  = 4;

    // Idle bus levels loaded into the synchronizer on reset: CS and panel
    // reset deasserted (high), SCL/MOSI/DC low. Loading idle levels keeps a
    // system reset from looking like a panel reset or a chip select.
    localparam logic [BUS_W-1:0] BUS_IDLE = 5'b10100;

endpackage

// File: rtl/lcd_spi_sync.sv
// N-bit multi-flop synchronizer with a rising-edge detector on one bit.
// The edge is taken from the last synchronized stage and one extra delay
// flop, so rise_o is aligned with q_o (data sampled with the same edge).
module lcd_spi_sync #(
    parameter int             N           = 5,
    parameter int             SYNC_STAGES = 2,
    parameter logic [N-1:0]   RST_VAL     = '0,
    parameter int             RISE_BIT    = 0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o,
    output logic         rise_o
);

    // Fewer than two stages is not a safe synchronizer; clamp to two.
    localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [DEPTH-1:0][N-1:0] stage_q;
    logic                    prev_q;

    // Synchronizer chain plus the delayed copy of the edge-detect bit.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stage_q <= {DEPTH{RST_VAL}};
            prev_q  <= RST_VAL[RISE_BIT];
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[DEPTH-1][RISE_BIT];
        end
    end

    assign q_o    = stage_q[DEPTH-1];
    assign rise_o = stage_q[DEPTH-1][RISE_BIT] & ~prev_q;

endmodule

// File: rtl/lcd_spi_decoder.sv
// Passive receive-side decoder for the 4-wire LCD SPI bus. Oversamples the
// bus on CLK, reassembles MSB-first bytes, classifies them via DC and tracks
// the active command and the parameter index within it. Never drives the bus.
module lcd_spi_decoder
    import lcd_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SCL,
    input  logic             MOSI,
    input  logic             CS,
    input  logic             DC,
    input  logic             LCD_RST,
    output logic             BYTE_VALID,
    output logic [7:0]       BYTE_DATA,
    output logic             BYTE_IS_CMD,
    output logic [7:0]       CUR_CMD,
    output logic [IDX_W-1:0] PARAM_IDX,
    output logic             FRAG_ERR,
    output logic             PANEL_RST_SEEN
);

    // ------------------------------------------------------------------
    // Bus synchronization
    // ------------------------------------------------------------------
    logic [BUS_W-1:0] bus_raw;
    logic [BUS_W-1:0] bus_s;
    logic             scl_rise;

    assign bus_raw[BUS_SCL]  = SCL;
    assign bus_raw[BUS_MOSI] = MOSI;
    assign bus_raw[BUS_CS]   = CS;
    assign bus_raw[BUS_DC]   = DC;
    assign bus_raw[BUS_RST]  = LCD_RST;

    lcd_spi_sync #(
        .N           (BUS_W),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (BUS_IDLE),
        .RISE_BIT    (BUS_SCL)
    ) u_sync (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .d_i     (bus_raw),
        .q_o     (bus_s),
        .rise_o  (scl_rise)
    );

    logic mosi_s, cs_s, dc_s, lcd_rst_s;
    assign mosi_s    = bus_s[BUS_MOSI];
    assign cs_s      = bus_s[BUS_CS];
    assign dc_s      = bus_s[BUS_DC];
    assign lcd_rst_s = bus_s[BUS_RST];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lcd_spi_state_e   state_q;
    logic [2:0]       bit_cnt_q;
    logic [6:0]       shreg_q;
    logic             byte_valid_q;
    logic [7:0]       byte_data_q;
    logic             byte_is_cmd_q;
    logic [7:0]       cur_cmd_q;
    logic [IDX_W-1:0] param_idx_q;
    logic             first_param_q;
    logic             frag_err_q;
    logic             rst_seen_q;

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic             byte_done;
    logic [7:0]       new_byte;
    logic [IDX_W-1:0] param_idx_d;

    // A byte completes on the 8th SCL rise while collecting, even if CS
    // rises in the same synchronized sample.
    assign byte_done = (state_q == ST_SHIFT) && scl_rise && (bit_cnt_q == 3'd7);
    assign new_byte  = {shreg_q, mosi_s};

    // Parameter index: first parameter after a command is 0, then count up
    // and saturate at all-ones rather than wrapping.
    always_comb begin
        param_idx_d = param_idx_q;
        if (first_param_q) begin
            param_idx_d = '0;
        end else if (!(&param_idx_q)) begin
            param_idx_d = param_idx_q + IDX_W'(1);
        end
    end

    // Receive FSM, byte assembly, command tracking and status flags.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            byte_is_cmd_q <= 1'b0;
            cur_cmd_q     <= CMD_NOP;
            param_idx_q   <= '0;
            first_param_q <= 1'b1;
            frag_err_q    <= 1'b0;
            rst_seen_q    <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frag_err_q   <= 1'b0;

            if (!lcd_rst_s) begin
                // Panel reset overrides everything: drop partial bits and
                // forget the active command; no byte or error this cycle.
                state_q       <= ST_IDLE;
                bit_cnt_q     <= '0;
                shreg_q       <= '0;
                cur_cmd_q     <= CMD_NOP;
                param_idx_q   <= '0;
                first_param_q <= 1'b1;
                rst_seen_q    <= 1'b1;
            end else begin
                if (byte_done) begin
                    byte_valid_q  <= 1'b1;
                    byte_data_q   <= new_byte;
                    byte_is_cmd_q <= ~dc_s;
                    if (!dc_s) begin
                        cur_cmd_q     <= new_byte;
                        param_idx_q   <= '0;
                        first_param_q <= 1'b1;
                    end else begin
                        param_idx_q   <= param_idx_d;
                        first_param_q <= 1'b0;
                    end
                end

                case (state_q)
                    ST_IDLE: begin
                        if (!cs_s) begin
                            state_q   <= ST_SHIFT;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (cs_s) begin
                            // Frame ended; a nonzero count means bits were
                            // left over, unless this very sample finished
                            // the byte.
                            state_q   <= ST_IDLE;
                            bit_cnt_q <= '0;
                            shreg_q   <= '0;
                            if (!byte_done && (bit_cnt_q != 3'd0)) begin
                                frag_err_q <= 1'b1;
                            end
                        end else if (scl_rise) begin
                            // Count wraps 7 -> 0 on byte completion, so
                            // multi-byte frames continue seamlessly.
                            shreg_q   <= {shreg_q[5:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign BYTE_VALID     = byte_valid_q;
    assign BYTE_DATA      = byte_data_q;
    assign BYTE_IS_CMD    = byte_is_cmd_q;
    assign CUR_CMD        = cur_cmd_q;
    assign PARAM_IDX      = param_idx_q;
    assign FRAG_ERR       = frag_err_q;
    assign PANEL_RST_SEEN = rst_seen_q;

endmodule

// File: tb/tb_lcd_spi_decoder.sv
// Directed bench for lcd_spi_decoder: drives the bus pins at a slow SCL
// (2 CLK low / 2 CLK high), logs every BYTE_VALID into a queue and compares
// against hand-computed expectations.
module tb_lcd_spi_decoder;

    // Narrow index so saturation is reachable in a short burst.
    localparam int TB_IDX_W = 4;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic                SCL = 1'b0;
    logic                MOSI = 1'b0;
    logic                CS = 1'b1;
    logic                DC = 1'b0;
    logic                LCD_RST = 1'b1;
    logic                BYTE_VALID;
    logic [7:0]          BYTE_DATA;
    logic                BYTE_IS_CMD;
    logic [7:0]          CUR_CMD;
    logic [TB_IDX_W-1:0] PARAM_IDX;
    logic                FRAG_ERR;
    logic                PANEL_RST_SEEN;

    lcd_spi_decoder #(
        .SYNC_STAGES (2),
        .IDX_W       (TB_IDX_W)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .SCL            (SCL),
        .MOSI           (MOSI),
        .CS             (CS),
        .DC             (DC),
        .LCD_RST        (LCD_RST),
        .BYTE_VALID     (BYTE_VALID),
        .BYTE_DATA      (BYTE_DATA),
        .BYTE_IS_CMD    (BYTE_IS_CMD),
        .CUR_CMD        (CUR_CMD),
        .PARAM_IDX      (PARAM_IDX),
        .FRAG_ERR       (FRAG_ERR),
        .PANEL_RST_SEEN (PANEL_RST_SEEN)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int frag_cnt = 0;

    typedef struct packed {
        logic [7:0]          d;
        logic                c;
        logic [7:0]          cur;
        logic [TB_IDX_W-1:0] idx;
    } ev_t;
    ev_t evq[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Log completed bytes and count FRAG_ERR cycles, sampled on the falling edge.
    always @(negedge CLK) begin
        ev_t e;
        if (BYTE_VALID) begin
            e.d   = BYTE_DATA;
            e.c   = BYTE_IS_CMD;
            e.cur = CUR_CMD;
            e.idx = PARAM_IDX;
            evq.push_back(e);
        end
        if (FRAG_ERR) frag_cnt++;
    end

    // Runaway guard.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bit_phase(input logic b, input logic dc);
        MOSI = b;
        DC   = dc;
        SCL  = 1'b0;
        tick(2);
        SCL  = 1'b1;
        tick(2);
    endtask

    // Send the top n bits of v, MSB first, leaving SCL low.
    task automatic send_bits(input logic [7:0] v, input int n, input logic dc);
        for (int i = 7; i > 7 - n; i--) bit_phase(v[i], dc);
        SCL = 1'b0;
    endtask

    task automatic frame(input logic [7:0] v, input logic dc);
        CS = 1'b0;
        tick(2);
        send_bits(v, 8, dc);
        tick(2);
        CS = 1'b1;
        tick(4);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] d, input logic c,
                               input logic [7:0] cur, input int idx);
        ev_t e;
        chk({tag, ".avail"}, 32'(evq.size() > 0), 32'd1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({tag, ".data"}, 32'(e.d), 32'(d));
            chk({tag, ".cmd"},  32'(e.c), 32'(c));
            chk({tag, ".cur"},  32'(e.cur), 32'(cur));
            chk({tag, ".idx"},  32'(e.idx), 32'(idx));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(BYTE_VALID), 32'd0);
        chk({tag, ".data"},  32'(BYTE_DATA), 32'd0);
        chk({tag, ".iscmd"}, 32'(BYTE_IS_CMD), 32'd0);
        chk({tag, ".cur"},   32'(CUR_CMD), 32'd0);
        chk({tag, ".idx"},   32'(PARAM_IDX), 32'd0);
        chk({tag, ".frag"},  32'(FRAG_ERR), 32'd0);
        chk({tag, ".seen"},  32'(PANEL_RST_SEEN), 32'd0);
    endtask

    int  lat;
    logic got;

    initial begin
        // Reset state
        tick(3);
        chk_all_zero("reset");
        RST_N = 1'b1;
        tick(4);

        // Command 0xB1 with three parameters, CS high between bytes
        frame(8'hB1, 1'b0);
        frame(8'h05, 1'b1);
        frame(8'h3C, 1'b1);
        frame(8'h3C, 1'b1);
        expect_byte("b1_cmd", 8'hB1, 1'b1, 8'hB1, 0);
        expect_byte("b1_p0",  8'h05, 1'b0, 8'hB1, 0);
        expect_byte("b1_p1",  8'h3C, 1'b0, 8'hB1, 1);
        expect_byte("b1_p2",  8'h3C, 1'b0, 8'hB1, 2);
        chk("b1_nofrag", 32'(frag_cnt), 32'd0);

        // RAMWR then a 20-byte burst under one CS; index saturates at 15
        CS = 1'b0;
        tick(2);
        send_bits(8'h2C, 8, 1'b0);
        for (int i = 0; i < 20; i++) send_bits(8'hFF, 8, 1'b1);
        tick(2);
        CS = 1'b1;
        tick(4);
        expect_byte("ramwr_cmd", 8'h2C, 1'b1, 8'h2C, 0);
        for (int i = 0; i < 20; i++)
            expect_byte($sformatf("ramwr_p%0d", i), 8'hFF, 1'b0, 8'h2C, (i > 15) ? 15 : i);
        chk("ramwr_nofrag", 32'(frag_cnt), 32'd0);

        // CS high after 5 bits of 0xA0: one FRAG_ERR pulse, no byte
        CS = 1'b0;
        tick(2);
        send_bits(8'hA0, 5, 1'b0);
        CS = 1'b1;
        tick(6);
        chk("frag_pulse", 32'(frag_cnt), 32'd1);
        chk("frag_nobyte", 32'(evq.size()), 32'd0);
        frame(8'h29, 1'b0);
        expect_byte("after_frag", 8'h29, 1'b1, 8'h29, 0);

        // Panel reset mid-byte after command 0x36
        frame(8'h36, 1'b0);
        CS = 1'b0;
        tick(2);
        send_bits(8'hF0, 3, 1'b1);
        LCD_RST = 1'b0;
        tick(4);
        chk("prst_cur",  32'(CUR_CMD), 32'd0);
        chk("prst_seen", 32'(PANEL_RST_SEEN), 32'd1);
        CS = 1'b1;
        tick(2);
        LCD_RST = 1'b1;
        tick(4);
        frame(8'h3A, 1'b0);
        expect_byte("pre_prst", 8'h36, 1'b1, 8'h36, 0);
        expect_byte("post_prst", 8'h3A, 1'b1, 8'h3A, 0);
        chk("prst_nofrag", 32'(frag_cnt), 32'd1);
        chk("prst_seen_sticky", 32'(PANEL_RST_SEEN), 32'd1);

        // Latency: 8th SCL rise at the pin to BYTE_VALID = 3 CLK edges
        CS = 1'b0;
        tick(2);
        send_bits(8'h5A, 7, 1'b1);
        MOSI = 1'b0;
        SCL  = 1'b0;
        tick(2);
        SCL  = 1'b1;
        lat  = 0;
        got  = 1'b0;
        while (!got && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
            got = BYTE_VALID;
        end
        chk("latency", 32'(lat), 32'd3);
        tick(2);
        SCL = 1'b0;
        expect_byte("lat_byte", 8'h5A, 1'b0, 8'h3A, 0);

        // 8th rise coincident with CS rise: byte completes, no FRAG_ERR
        send_bits(8'hC3, 7, 1'b1);
        MOSI = 1'b1;
        SCL  = 1'b0;
        tick(2);
        SCL  = 1'b1;
        CS   = 1'b1;
        tick(2);
        SCL  = 1'b0;
        tick(4);
        expect_byte("coinc", 8'hC3, 1'b0, 8'h3A, 1);
        chk("coinc_nofrag", 32'(frag_cnt), 32'd1);

        // RST_N mid-frame clears all outputs; next byte decodes from bit 0
        CS = 1'b0;
        tick(2);
        send_bits(8'h11, 8, 1'b0);
        tick(4);
        send_bits(8'hFF, 3, 1'b1);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        chk_all_zero("rstn_mid");
        tick(2);
        RST_N = 1'b1;
        tick(4);
        send_bits(8'h42, 8, 1'b0);
        tick(2);
        CS = 1'b1;
        tick(4);
        expect_byte("pre_rstn", 8'h11, 1'b1, 8'h11, 0);
        expect_byte("post_rstn", 8'h42, 1'b1, 8'h42, 0);
        chk("rstn_nofrag", 32'(frag_cnt), 32'd1);
        chk("no_extra_bytes", 32'(evq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
